decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Registered, parametrised decode stage between fetch and execute. Buffers fetched instructions in
//  a DEPTH-entry queue, decodes the queue head and registers the control bundle with a valid/ready
//  handshake. Adds sign-extended immediates, an illegal-instruction flag, a load-use bubble and flush.
// PARAMETERS
//  XLEN   32  instruction/PC/immediate width (>=32; fields taken from bits [31:0])
//  DEPTH  2   instruction queue entries (power of two, >=2)
// PORTS
//  clk        in   1     clock, rising edge
//  rst_n      in   1     asynchronous active-low reset
//  flush      in   1     synchronous kill of queue + output register (branch redirect)
//  f_valid    in   1     fetch offers f_inst/f_pc
//  f_ready    out  1     queue can accept (= !full)
//  f_inst     in   XLEN  instruction: opc[31:26] ra[25:21] rb[20:16] rd[15:11] imm[10:0]
//  f_pc       in   XLEN  PC of f_inst
//  e_valid    out  1     output bundle valid
//  e_ready    in   1     execute accepts bundle
//  e_pc       out  XLEN  PC of bundle
//  e_ra/e_rb/e_rd  out 5 register fields
//  e_imm      out  XLEN  imm[10:0] sign-extended to XLEN
//  e_alu_op   out  4     ALU op code
//  e_we,e_ld,e_str,e_byt,e_brn,e_addi,e_mul,e_jmp,e_link_we  out 1 each  control flags
//  e_illegal  out  1     undefined opcode / CTRL sub-op
// BEHAVIOUR
//  - Reset: queue empty, all e_* outputs 0, f_ready=1 once released.
//  - Push when f_valid&&f_ready&&!flush. Full: f_ready=0, no same-cycle push/pop bypass.
//  - Output reg advances when adv = !e_valid || e_ready. On adv: queue non-empty and no hazard ->
//    pop head, load decoded bundle, e_valid=1; else e_valid=0 (bubble). !adv: all e_* held stable.
//  - Latency: instruction pushed at edge N is earliest visible (e_valid=1) after edge N+1.
//  - Load-use hazard = e_valid && e_ld && e_rd!=0 && (head.ra==e_rd || head.rb==e_rd); inserts
//    exactly one bubble; head issues next adv.
//  - flush: queue emptied, e_valid=0 next edge; beats offered/pushed that cycle are dropped;
//    flush overrides push, pop and hazard. rst_n low mid-operation: same as reset, immediately.
//  - Decode (opc=inst[31:26]): ADD0 SUB1 AND2 OR3 XOR4 NOT5 SHL6 SHR7 ADDI8 LT9 GT10 CTRL13 MUL14;
//    LOAD opc[4:0]=01011, STORE opc[4:0]=01100, opc[5]=byte (e_byt). CTRL sub-op in rd:
//    JMP0 BEQ1 BLT2 BGT3 JALX4.
//  - alu_op: opc0..7 -> same value; BEQ 8; LT/BLT 9; GT/BGT 10; MUL 11; else 0.
//  - e_we = opc<=10 || ld || mul; e_brn = CTRL; e_jmp = JMP; e_link_we = JALX; e_addi = opc==8.
//  - Legal: opc 0..10,11,12,13,14, 0x2B, 0x2C; CTRL with rd>4 illegal. Illegal: e_illegal=1,
//    e_valid as normal, every other control flag 0, alu_op 0.
//  - Queue pointers wrap modulo DEPTH; occupancy counter log2(DEPTH)+1 bits.
// STRUCTURE
//  - decode_pkg: opcode, CTRL sub-op and ALU-op localparams; decode_bundle field widths.
//  - Sub-module decode_fifo (DEPTH x {pc,inst}, push/pop/flush, full/empty); decode logic and
//    output register in decode_stage.
// TESTING
//  - ADD 0x00221800, e_ready=1 -> e_valid 2 cycles after push, ra1 rb2 rd3 alu0 we1 illegal0.
//  - ADDI 0x202017FF -> e_imm=0xFFFFFFFF, addi1 we1 alu0; BLT 0x34001000 -> brn1 alu9 we0;
//    JALX 0x34002000 -> link_we1 alu0; byte load 0xAC000000 -> ld1 byt1 we1.
//  - LOAD 0x2C202800 then ADD 0x00A03000 back-to-back -> exactly one e_valid=0 cycle between them.
//  - e_ready=0, push 3 instrs (DEPTH=2) -> f_ready=0 after 3rd accepted, e_* stable; release e_ready
//    -> program order preserved, nothing lost or duplicated.
//  - Queue full + flush with f_valid=1 -> next cycle empty, e_valid=0, f_ready=1, offered inst dropped.
//  - Opc 0x3C000000 and CTRL rd=5 (0x34002800) -> e_illegal=1, we/str/brn/ld=0; rst_n low mid-stream
//    -> e_valid=0 asynchronously.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared opcode, CTRL sub-op and ALU-op constants plus the control-flag bundle
// and the pure decode function used by decode_stage.
package decode_pkg;

  localparam int OPC_W = 6;
  localparam int REG_W = 5;
  localparam int ALU_W = 4;
  localparam int IMM_W = 11;

  localparam logic [OPC_W-1:0] OPC_SHR  = 6'd7;
  localparam logic [OPC_W-1:0] OPC_ADDI = 6'd8;
  localparam logic [OPC_W-1:0] OPC_LT   = 6'd9;
  localparam logic [OPC_W-1:0] OPC_GT   = 6'd10;
  localparam logic [OPC_W-1:0] OPC_CTRL = 6'd13;
  localparam logic [OPC_W-1:0] OPC_MUL  = 6'd14;

  // Loads and stores match on the low five bits; bit 5 selects byte access.
  localparam logic [4:0] OPC_LOAD_LO  = 5'b01011;
  localparam logic [4:0] OPC_STORE_LO = 5'b01100;

  localparam logic [REG_W-1:0] SUB_JMP  = 5'd0;
  localparam logic [REG_W-1:0] SUB_BEQ  = 5'd1;
  localparam logic [REG_W-1:0] SUB_BLT  = 5'd2;
  localparam logic [REG_W-1:0] SUB_BGT  = 5'd3;
  localparam logic [REG_W-1:0] SUB_JALX = 5'd4;

  localparam logic [ALU_W-1:0] ALU_BEQ = 4'd8;
  localparam logic [ALU_W-1:0] ALU_LT  = 4'd9;
  localparam logic [ALU_W-1:0] ALU_GT  = 4'd10;
  localparam logic [ALU_W-1:0] ALU_MUL = 4'd11;

  typedef struct packed {
    logic [ALU_W-1:0] alu_op;
    logic             we;
    logic             ld;
    logic             str;
    logic             byt;
    logic             brn;
    logic             addi;
    logic             mul;
    logic             jmp;
    logic             link_we;
    logic             illegal;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [OPC_W-1:0] opc,
                                        input logic [REG_W-1:0] sub);
    ctrl_t c;
    c = '0;
    if (opc <= OPC_SHR) begin
      c.alu_op = opc[ALU_W-1:0];
      c.we     = 1'b1;
    end else begin
      case (opc)
        OPC_ADDI: begin c.we = 1'b1; c.addi = 1'b1; end
        OPC_LT:   begin c.we = 1'b1; c.alu_op = ALU_LT; end
        OPC_GT:   begin c.we = 1'b1; c.alu_op = ALU_GT; end
        OPC_MUL:  begin c.we = 1'b1; c.mul = 1'b1; c.alu_op = ALU_MUL; end
        OPC_CTRL: begin
          c.brn = 1'b1;
          case (sub)
            SUB_JMP:  c.jmp     = 1'b1;
            SUB_BEQ:  c.alu_op  = ALU_BEQ;
            SUB_BLT:  c.alu_op  = ALU_LT;
            SUB_BGT:  c.alu_op  = ALU_GT;
            SUB_JALX: c.link_we = 1'b1;
            default:  begin c.brn = 1'b0; c.illegal = 1'b1; end
          endcase
        end
        default: begin
          if (opc[4:0] == OPC_LOAD_LO) begin
            c.ld  = 1'b1;
            c.we  = 1'b1;
            c.byt = opc[5];
          end else if (opc[4:0] == OPC_STORE_LO) begin
            c.str = 1'b1;
            c.byt = opc[5];
          end else begin
            c.illegal = 1'b1;
          end
        end
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/decode_fifo.sv
// DEPTH-entry instruction queue holding {pc, inst}; head is read combinationally.
// Synchronous flush empties it; pointers wrap naturally because DEPTH is a power of two.
module decode_fifo #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_flush,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_inst,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_inst,
  output logic            o_full,
  output logic            o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [XLEN-1:0]  r_pc_mem   [DEPTH];
  logic [XLEN-1:0]  r_inst_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  // NOTE: storage has no reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_pc_mem[r_wr_ptr]   <= i_pc;
      r_inst_mem[r_wr_ptr] <= i_inst;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_pc    = r_pc_mem[r_rd_ptr];
  assign o_inst  = r_inst_mem[r_rd_ptr];
  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/decode_stage.sv
// Decode stage: queues fetched instructions, decodes the head and registers the
// control bundle behind a valid/ready handshake, with load-use bubble and flush.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             f_valid,
  output logic             f_ready,
  input  logic [XLEN-1:0]  f_inst,
  input  logic [XLEN-1:0]  f_pc,
  output logic             e_valid,
  input  logic             e_ready,
  output logic [XLEN-1:0]  e_pc,
  output logic [REG_W-1:0] e_ra,
  output logic [REG_W-1:0] e_rb,
  output logic [REG_W-1:0] e_rd,
  output logic [XLEN-1:0]  e_imm,
  output logic [ALU_W-1:0] e_alu_op,
  output logic             e_we,
  output logic             e_ld,
  output logic             e_str,
  output logic             e_byt,
  output logic             e_brn,
  output logic             e_addi,
  output logic             e_mul,
  output logic             e_jmp,
  output logic             e_link_we,
  output logic             e_illegal
);

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_adv;
  logic             w_hazard;
  logic [XLEN-1:0]  w_head_pc;
  logic [XLEN-1:0]  w_head_inst;
  logic [REG_W-1:0] w_head_ra;
  logic [REG_W-1:0] w_head_rb;
  logic [REG_W-1:0] w_head_rd;
  logic [XLEN-1:0]  w_head_imm;
  ctrl_t            w_ctrl;

  logic             r_valid;
  logic [XLEN-1:0]  r_pc;
  logic [REG_W-1:0] r_ra;
  logic [REG_W-1:0] r_rb;
  logic [REG_W-1:0] r_rd;
  logic [XLEN-1:0]  r_imm;
  ctrl_t            r_ctrl;

  decode_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_pc    (f_pc),
    .i_inst  (f_inst),
    .o_pc    (w_head_pc),
    .o_inst  (w_head_inst),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head_ra  = w_head_inst[25:21];
  assign w_head_rb  = w_head_inst[20:16];
  assign w_head_rd  = w_head_inst[15:11];
  assign w_head_imm = {{(XLEN-IMM_W){w_head_inst[IMM_W-1]}}, w_head_inst[IMM_W-1:0]};
  assign w_ctrl     = decode_ctrl(w_head_inst[31:26], w_head_rd);

  // A load still sitting in the output register cannot feed the head this cycle.
  assign w_hazard = r_valid && r_ctrl.ld && (r_rd != '0) &&
                    ((w_head_ra == r_rd) || (w_head_rb == r_rd));

  assign f_ready = !w_full;
  assign w_push  = f_valid && !w_full && !flush;
  assign w_adv   = !r_valid || e_ready;
  assign w_pop   = w_adv && !w_empty && !w_hazard && !flush;

  // Bubbles only drop valid; the payload is left as-is since nothing reads it then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_ra    <= '0;
      r_rb    <= '0;
      r_rd    <= '0;
      r_imm   <= '0;
      r_ctrl  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_adv) begin
      r_valid <= w_pop;
      if (w_pop) begin
        r_pc   <= w_head_pc;
        r_ra   <= w_head_ra;
        r_rb   <= w_head_rb;
        r_rd   <= w_head_rd;
        r_imm  <= w_head_imm;
        r_ctrl <= w_ctrl;
      end
    end
  end

  assign e_valid   = r_valid;
  assign e_pc      = r_pc;
  assign e_ra      = r_ra;
  assign e_rb      = r_rb;
  assign e_rd      = r_rd;
  assign e_imm     = r_imm;
  assign e_alu_op  = r_ctrl.alu_op;
  assign e_we      = r_ctrl.we;
  assign e_ld      = r_ctrl.ld;
  assign e_str     = r_ctrl.str;
  assign e_byt     = r_ctrl.byt;
  assign e_brn     = r_ctrl.brn;
  assign e_addi    = r_ctrl.addi;
  assign e_mul     = r_ctrl.mul;
  assign e_jmp     = r_ctrl.jmp;
  assign e_link_we = r_ctrl.link_we;
  assign e_illegal = r_ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode of each instruction class, latency,
// load-use bubble, backpressure with a full queue, flush and async reset.
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        f_valid;
  logic        f_ready;
  logic [31:0] f_inst;
  logic [31:0] f_pc;
  logic        e_valid;
  logic        e_ready;
  logic [31:0] e_pc;
  logic [4:0]  e_ra;
  logic [4:0]  e_rb;
  logic [4:0]  e_rd;
  logic [31:0] e_imm;
  logic [3:0]  e_alu_op;
  logic        e_we;
  logic        e_ld;
  logic        e_str;
  logic        e_byt;
  logic        e_brn;
  logic        e_addi;
  logic        e_mul;
  logic        e_jmp;
  logic        e_link_we;
  logic        e_illegal;

  int n_checks;
  int n_errors;

  decode_stage #(
    .XLEN  (32),
    .DEPTH (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .f_valid   (f_valid),
    .f_ready   (f_ready),
    .f_inst    (f_inst),
    .f_pc      (f_pc),
    .e_valid   (e_valid),
    .e_ready   (e_ready),
    .e_pc      (e_pc),
    .e_ra      (e_ra),
    .e_rb      (e_rb),
    .e_rd      (e_rd),
    .e_imm     (e_imm),
    .e_alu_op  (e_alu_op),
    .e_we      (e_we),
    .e_ld      (e_ld),
    .e_str     (e_str),
    .e_byt     (e_byt),
    .e_brn     (e_brn),
    .e_addi    (e_addi),
    .e_mul     (e_mul),
    .e_jmp     (e_jmp),
    .e_link_we (e_link_we),
    .e_illegal (e_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction for a single cycle, then wait for it to reach the output.
  task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
    f_valid = 1'b1;
    f_inst  = inst;
    f_pc    = pc;
    step();
    f_valid = 1'b0;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    f_valid  = 1'b0;
    f_inst   = '0;
    f_pc     = '0;
    e_ready  = 1'b1;
    #1;
    check("reset_e_valid", 64'(e_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("reset_f_ready", 64'(f_ready), 64'd1);
    check("reset_e_valid2", 64'(e_valid), 64'd0);
    check("reset_e_pc", 64'(e_pc), 64'd0);
    check("reset_e_we", 64'(e_we), 64'd0);
    check("reset_alu", 64'(e_alu_op), 64'd0);

    // ADD: visible one edge after the push edge.
    f_valid = 1'b1; f_inst = 32'h0022_1800; f_pc = 32'h100;
    step();
    f_valid = 1'b0;
    check("add_not_yet", 64'(e_valid), 64'd0);
    step();
    check("add_valid", 64'(e_valid), 64'd1);
    check("add_pc", 64'(e_pc), 64'h100);
    check("add_ra", 64'(e_ra), 64'd1);
    check("add_rb", 64'(e_rb), 64'd2);
    check("add_rd", 64'(e_rd), 64'd3);
    check("add_alu", 64'(e_alu_op), 64'd0);
    check("add_we", 64'(e_we), 64'd1);
    check("add_illegal", 64'(e_illegal), 64'd0);
    check("add_imm", 64'(e_imm), 64'd0);
    step();
    check("add_drained", 64'(e_valid), 64'd0);

    issue(32'h2020_17FF, 32'h104);
    check("addi_valid", 64'(e_valid), 64'd1);
    check("addi_imm", 64'(e_imm), 64'hFFFF_FFFF);
    check("addi_addi", 64'(e_addi), 64'd1);
    check("addi_we", 64'(e_we), 64'd1);
    check("addi_alu", 64'(e_alu_op), 64'd0);
    check("addi_rd", 64'(e_rd), 64'd2);
    step();

    issue(32'h3400_1000, 32'h108);
    check("blt_brn", 64'(e_brn), 64'd1);
    check("blt_alu", 64'(e_alu_op), 64'd9);
    check("blt_we", 64'(e_we), 64'd0);
    check("blt_jmp", 64'(e_jmp), 64'd0);
    step();

    issue(32'h3400_2000, 32'h10C);
    check("jalx_link", 64'(e_link_we), 64'd1);
    check("jalx_alu", 64'(e_alu_op), 64'd0);
    check("jalx_brn", 64'(e_brn), 64'd1);
    check("jalx_we", 64'(e_we), 64'd0);
    step();

    issue(32'hAC00_0000, 32'h110);
    check("lb_ld", 64'(e_ld), 64'd1);
    check("lb_byt", 64'(e_byt), 64'd1);
    check("lb_we", 64'(e_we), 64'd1);
    check("lb_str", 64'(e_str), 64'd0);
    step();

    issue(32'h3000_0000, 32'h114);
    check("sw_str", 64'(e_str), 64'd1);
    check("sw_byt", 64'(e_byt), 64'd0);
    check("sw_we", 64'(e_we), 64'd0);
    step();

    issue(32'h3800_0000, 32'h118);
    check("mul_mul", 64'(e_mul), 64'd1);
    check("mul_alu", 64'(e_alu_op), 64'd11);
    check("mul_we", 64'(e_we), 64'd1);
    step();

    issue(32'h3C00_0000, 32'h11C);
    check("ill_opc_valid", 64'(e_valid), 64'd1);
    check("ill_opc_flag", 64'(e_illegal), 64'd1);
    check("ill_opc_ctl", 64'({e_we, e_str, e_brn, e_ld, e_alu_op}), 64'd0);
    step();

    issue(32'h3400_2800, 32'h120);
    check("ill_ctrl_flag", 64'(e_illegal), 64'd1);
    check("ill_ctrl_ctl", 64'({e_we, e_str, e_brn, e_ld, e_link_we, e_jmp}), 64'd0);
    step();
    check("idle_before_lu", 64'(e_valid), 64'd0);

    // Load-use: LOAD r5 then ADD reading r5 gives exactly one bubble.
    f_valid = 1'b1; f_inst = 32'h2C20_2800; f_pc = 32'h400;
    step();
    f_inst = 32'h00A0_3000; f_pc = 32'h404;
    step();
    f_valid = 1'b0;
    check("lu_load_valid", 64'(e_valid), 64'd1);
    check("lu_load_pc", 64'(e_pc), 64'h400);
    check("lu_load_ld", 64'(e_ld), 64'd1);
    check("lu_load_rd", 64'(e_rd), 64'd5);
    step();
    check("lu_bubble", 64'(e_valid), 64'd0);
    step();
    check("lu_add_valid", 64'(e_valid), 64'd1);
    check("lu_add_pc", 64'(e_pc), 64'h404);
    check("lu_add_rd", 64'(e_rd), 64'd6);
    step();
    check("lu_drained", 64'(e_valid), 64'd0);

    // Backpressure: three pushes fill output plus both queue entries.
    e_ready = 1'b0;
    f_valid = 1'b1; f_inst = 32'h0022_1800; f_pc = 32'h200;
    step();
    f_inst = 32'h0443_2000; f_pc = 32'h204;
    step();
    check("bp_out1_pc", 64'(e_pc), 64'h200);
    check("bp_ready_before3", 64'(f_ready), 64'd1);
    f_inst = 32'h0800_0000; f_pc = 32'h208;
    step();
    check("bp_full", 64'(f_ready), 64'd0);
    check("bp_hold_pc", 64'(e_pc), 64'h200);
    f_inst = 32'h0C00_0000; f_pc = 32'h20C;
    step();
    check("bp_still_full", 64'(f_ready), 64'd0);
    check("bp_hold_pc2", 64'(e_pc), 64'h200);
    check("bp_hold_rd", 64'(e_rd), 64'd3);
    check("bp_hold_valid", 64'(e_valid), 64'd1);
    f_valid = 1'b0;
    e_ready = 1'b1;
    step();
    check("bp_order2_pc", 64'(e_pc), 64'h204);
    check("bp_order2_alu", 64'(e_alu_op), 64'd1);
    check("bp_ready_again", 64'(f_ready), 64'd1);
    step();
    check("bp_order3_pc", 64'(e_pc), 64'h208);
    check("bp_order3_alu", 64'(e_alu_op), 64'd2);
    step();
    check("bp_no_dup", 64'(e_valid), 64'd0);

    // Flush with the queue full and a beat offered.
    e_ready = 1'b0;
    f_valid = 1'b1; f_inst = 32'h0022_1800; f_pc = 32'h500;
    step();
    f_inst = 32'h0443_2000; f_pc = 32'h504;
    step();
    f_inst = 32'h0800_0000; f_pc = 32'h508;
    step();
    check("fl_full_before", 64'(f_ready), 64'd0);
    f_inst = 32'h0C00_0000; f_pc = 32'h50C;
    flush = 1'b1;
    step();
    flush   = 1'b0;
    f_valid = 1'b0;
    check("fl_valid", 64'(e_valid), 64'd0);
    check("fl_ready", 64'(f_ready), 64'd1);
    e_ready = 1'b1;
    step();
    check("fl_empty1", 64'(e_valid), 64'd0);
    step();
    check("fl_empty2", 64'(e_valid), 64'd0);

    // Flush on an empty queue drops a beat that would otherwise be accepted.
    f_valid = 1'b1; f_inst = 32'h0022_1800; f_pc = 32'h600;
    flush = 1'b1;
    step();
    flush   = 1'b0;
    f_valid = 1'b0;
    step();
    step();
    check("fl_drop_beat", 64'(e_valid), 64'd0);

    // Asynchronous reset while a bundle is held.
    e_ready = 1'b0;
    issue(32'h0022_1800, 32'h700);
    check("ar_held", 64'(e_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 64'(e_valid), 64'd0);
    check("ar_pc", 64'(e_pc), 64'd0);
    check("ar_ready", 64'(f_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("ar_after", 64'(e_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
